// File: rtl/axi_stream_arb_pkg.sv
// ============================================================================
//  Module   : axi_stream_arb_pkg
//  Purpose  : Shared types and helpers for the packet-granular AXI4-Stream
//             round-robin arbiter (FSM state encoding, index width helper,
//             behavioural round-robin reference function).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_stream_arb_pkg;

  // Two-state arbiter FSM: IDLE arbitrates, BUSY forwards one whole packet.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned src_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Reference round-robin choice: first requester after 'last', wrapping.
  // Returns -1 when nobody requests.
  function automatic int rr_next(input logic [31:0] req, input int last, input int n);
    int pick;
    pick = -1;
    for (int k = n; k >= 1; k--) begin
      if (req[(last + k) % n]) pick = (last + k) % n;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_stream_rr_arbiter_rr_select.sv
// ============================================================================
//  Module   : rr_select
//  Purpose  : Combinational rotate-priority encoder. Picks the first asserted
//             request after 'last', wrapping from NUM_SOURCES-1 back to 0.
//  Ports    : req     in  NUM_SOURCES  request vector
//             last    in  SRC_W        index granted most recently
//             gnt_idx out SRC_W        selected index (0 when none)
//             any     out 1            at least one request present
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_select #(
  parameter int NUM_SOURCES = 4,
  parameter int SRC_W       = 2
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SRC_W-1:0]       last,
  output logic [SRC_W-1:0]       gnt_idx,
  output logic                   any
);

  int               w_idx;
  logic [SRC_W-1:0] w_idx_s;

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is the final (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    w_idx_s = '0;
    for (int k = NUM_SOURCES; k >= 1; k--) begin
      w_idx   = (int'(last) + k) % NUM_SOURCES;
      w_idx_s = SRC_W'(w_idx);
      if (req[w_idx_s]) begin
        gnt_idx = w_idx_s;
        any     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_stream_rr_arbiter.sv
// ============================================================================
//  Module   : axi_stream_rr_arbiter
//  Purpose  : Packet-granular round-robin arbiter sharing one AXI4-Stream
//             master among NUM_SOURCES slave ports. A grant is held from the
//             first beat through the TLAST beat; one idle arbitration cycle
//             separates packets. The granted index is driven on m_tid.
//  Ports    : aclk, aresetn (async, active-low)
//             s_tvalid/s_tready/s_tlast  per-source handshake and last
//             s_tdata/s_tkeep/s_tstrb/s_tuser  packed per source, slice i
//             m_tvalid/m_tready/m_tdata/m_tkeep/m_tstrb/m_tlast/m_tuser
//             m_tid  granted source index
//             busy   high while a packet is in progress
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_stream_rr_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter  int NUM_SOURCES = 4,
  parameter  int BYTE_WIDTH  = 4,
  parameter  int USER_WIDTH  = 1,
  localparam int SRC_W       = src_w(NUM_SOURCES)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_SOURCES-1:0]              s_tvalid,
  output logic [NUM_SOURCES-1:0]              s_tready,
  input  logic [NUM_SOURCES*8*BYTE_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES*BYTE_WIDTH-1:0]   s_tkeep,
  input  logic [NUM_SOURCES*BYTE_WIDTH-1:0]   s_tstrb,
  input  logic [NUM_SOURCES-1:0]              s_tlast,
  input  logic [NUM_SOURCES*USER_WIDTH-1:0]   s_tuser,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [8*BYTE_WIDTH-1:0]             m_tdata,
  output logic [BYTE_WIDTH-1:0]               m_tkeep,
  output logic [BYTE_WIDTH-1:0]               m_tstrb,
  output logic                                m_tlast,
  output logic [USER_WIDTH-1:0]               m_tuser,
  output logic [SRC_W-1:0]                    m_tid,
  output logic                                busy
);

  localparam int DATA_W = 8 * BYTE_WIDTH;

  arb_state_t       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_grant, w_grant_nxt;
  logic [SRC_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [SRC_W-1:0] w_sel_idx;
  logic             w_sel_any;
  logic             w_pkt_end;

  // Per-source views of the packed slave buses.
  logic [DATA_W-1:0]     w_data_arr [NUM_SOURCES];
  logic [BYTE_WIDTH-1:0] w_keep_arr [NUM_SOURCES];
  logic [BYTE_WIDTH-1:0] w_strb_arr [NUM_SOURCES];
  logic [USER_WIDTH-1:0] w_user_arr [NUM_SOURCES];

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_unpack
    assign w_data_arr[i] = s_tdata[i*DATA_W +: DATA_W];
    assign w_keep_arr[i] = s_tkeep[i*BYTE_WIDTH +: BYTE_WIDTH];
    assign w_strb_arr[i] = s_tstrb[i*BYTE_WIDTH +: BYTE_WIDTH];
    assign w_user_arr[i] = s_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  rr_select #(
    .NUM_SOURCES (NUM_SOURCES),
    .SRC_W       (SRC_W)
  ) u_rr_select (
    .req     (s_tvalid),
    .last    (r_last_grant),
    .gnt_idx (w_sel_idx),
    .any     (w_sel_any)
  );

  // Final beat of the granted packet is accepted by the sink.
  assign w_pkt_end = s_tvalid[r_grant] & m_tready & s_tlast[r_grant];

  // State register. last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= SRC_W'(NUM_SOURCES - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state logic. The grant only moves in IDLE, so it is frozen for the
  // whole packet.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ARB_IDLE: begin
        if (w_sel_any) begin
          w_grant_nxt = w_sel_idx;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (w_pkt_end) begin
          w_state_nxt      = ARB_IDLE;
          w_last_grant_nxt = r_grant;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output logic: combinational passthrough of the granted source; handshake
  // signals are gated off outside BUSY so the arbitration cycle is a bubble.
  always_comb begin
    m_tvalid = 1'b0;
    s_tready = '0;
    busy     = 1'b0;
    m_tid    = r_grant;
    m_tdata  = w_data_arr[r_grant];
    m_tkeep  = w_keep_arr[r_grant];
    m_tstrb  = w_strb_arr[r_grant];
    m_tuser  = w_user_arr[r_grant];
    m_tlast  = s_tlast[r_grant];
    if (r_state == ARB_BUSY) begin
      busy              = 1'b1;
      m_tvalid          = s_tvalid[r_grant];
      s_tready[r_grant] = m_tready;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_rr_arbiter.sv
// ============================================================================
//  Module   : tb_axi_stream_rr_arbiter
//  Purpose  : Self-checking bench for axi_stream_rr_arbiter (4 sources,
//             4-byte beats). Source queues drive packets; a packet-level
//             round-robin model predicts ownership, beat content and
//             handshakes; directed scenarios check grant order and stalls.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_stream_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   s_tvalid = '0;
  logic [3:0]   s_tready;
  logic [127:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic [15:0]  s_tstrb = '0;
  logic [3:0]   s_tlast = '0;
  logic [3:0]   s_tuser = '0;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic [3:0]   m_tstrb;
  logic         m_tlast;
  logic         m_tuser;
  logic [1:0]   m_tid;
  logic         busy;

  axi_stream_rr_arbiter #(.NUM_SOURCES(4), .BYTE_WIDTH(4), .USER_WIDTH(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int    checks = 0;
  int    failures = 0;
  beat_t srcq [N][$];
  bit    gap_mode = 0;
  bit    ready_rand = 0;
  logic [3:0] hs = '0;

  // Packet-level model state
  bit         in_pkt = 0;
  bit         arb_pending = 0;
  logic [3:0] arb_req = '0;
  int         owner = 0;
  int         mdl_last = N - 1;
  int         wait_cnt [N];
  int         beats_seen = 0;
  int         tid_log[$];
  int         beat_tid_log[$];

  // Previous-cycle master view for the stall-stability property
  bit         prev_stall = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep, prev_strb;
  logic        prev_last, prev_user;
  logic [1:0]  prev_tid;

  function automatic int rr_ref(input logic [3:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = $urandom;
      b.keep = 4'($urandom_range(1, 15));
      b.strb = b.keep & 4'($urandom);
      b.last = (k == len - 1);
      b.user = 1'($urandom);
      srcq[src].push_back(b);
    end
  endtask

  task automatic refresh();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*32 +: 32] = '0;
        s_tkeep[i*4 +: 4] = '0;
        s_tstrb[i*4 +: 4] = '0;
        s_tlast[i] = 1'b0;
        s_tuser[i] = 1'b0;
      end else begin
        if (!s_tvalid[i]) s_tvalid[i] = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        b = srcq[i][0];
        s_tdata[i*32 +: 32] = b.data;
        s_tkeep[i*4 +: 4] = b.keep;
        s_tstrb[i*4 +: 4] = b.strb;
        s_tlast[i] = b.last;
        s_tuser[i] = b.user;
      end
    end
    if (ready_rand) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sample();
    beat_t b;
    int    w;
    logic [3:0] exp_rdy;
    if (!aresetn) begin
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0 || m_tid !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle: got valid=%b busy=%b ready=%b tid=%0d expected 0 0 0000 0",
                 m_tvalid, busy, s_tready, m_tid);
      end
      in_pkt = 0; arb_pending = 0; mdl_last = N - 1; hs = '0; prev_stall = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      return;
    end
    if (prev_stall) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tkeep !== prev_keep ||
          m_tstrb !== prev_strb || m_tlast !== prev_last || m_tuser !== prev_user ||
          m_tid !== prev_tid) begin
        failures++;
        $display("FAIL stall_stable: got valid=%b data=%h tid=%0d expected valid=1 data=%h tid=%0d",
                 m_tvalid, m_tdata, m_tid, prev_data, prev_tid);
      end
    end
    if (!in_pkt && arb_pending) begin
      w = rr_ref(arb_req, mdl_last);
      in_pkt = 1; owner = w;
      tid_log.push_back(int'(m_tid));
      for (int i = 0; i < N; i++) begin
        if (arb_req[i] && i != w) begin
          wait_cnt[i]++;
          checks++;
          if (wait_cnt[i] > N - 1) begin
            failures++;
            $display("FAIL fairness: src%0d waited %0d packets expected <= %0d", i, wait_cnt[i], N - 1);
          end
        end
      end
      wait_cnt[w] = 0;
    end
    if (in_pkt) begin
      exp_rdy = m_tready ? 4'(1 << owner) : 4'b0;
      checks++;
      if (m_tvalid !== s_tvalid[owner] || busy !== 1'b1 || m_tid !== 2'(owner) || s_tready !== exp_rdy) begin
        failures++;
        $display("FAIL busy_ctrl: got valid=%b busy=%b tid=%0d ready=%b expected valid=%b busy=1 tid=%0d ready=%b",
                 m_tvalid, busy, m_tid, s_tready, s_tvalid[owner], owner, exp_rdy);
      end
      if (s_tvalid[owner] && srcq[owner].size() > 0) begin
        b = srcq[owner][0];
        checks++;
        if (m_tdata !== b.data || m_tkeep !== b.keep || m_tstrb !== b.strb ||
            m_tlast !== b.last || m_tuser !== b.user) begin
          failures++;
          $display("FAIL beat_data: got %h/%h/%h/%b/%b expected %h/%h/%h/%b/%b",
                   m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, b.data, b.keep, b.strb, b.last, b.user);
        end
        if (m_tready) begin
          beat_tid_log.push_back(int'(m_tid));
          beats_seen++;
          if (b.last) begin
            in_pkt = 0;
            mdl_last = owner;
          end
        end
      end
      arb_pending = 0;
    end else begin
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0) begin
        failures++;
        $display("FAIL idle_ctrl: got valid=%b busy=%b ready=%b expected 0 0 0000", m_tvalid, busy, s_tready);
      end
      arb_pending = |s_tvalid;
      arb_req = s_tvalid;
    end
    hs = s_tvalid & s_tready;
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata; prev_keep = m_tkeep; prev_strb = m_tstrb;
    prev_last = m_tlast; prev_user = m_tuser; prev_tid = m_tid;
  endtask

  task automatic cycle();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        s_tvalid[i] = 1'b0;
      end
    end
    hs = '0;
    refresh();
  endtask

  task automatic wait_idle();
    int n;
    bit pending;
    n = 0;
    pending = 1;
    while (pending && n < 3000) begin
      pending = in_pkt;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pending = 1;
      if (pending) cycle();
      n++;
    end
    checks++;
    if (pending) begin
      failures++;
      $display("FAIL drain_timeout: got pending traffic after %0d cycles expected drained", n);
    end
  endtask

  task automatic run_until_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 500) begin
      cycle();
      n++;
    end
    checks++;
    if (beats_seen < target) begin
      failures++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beats_seen, target);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    refresh();
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    gap_mode = 0; ready_rand = 0; m_tready = 1'b1;
    do_reset();
    cycle();
  endtask

  task automatic test_all_single();
    int base;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    base = tid_log.size();
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1);
    refresh();
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tid_log.size() <= base + k || tid_log[base + k] !== exp_seq[k]) begin
        failures++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", k,
                 (tid_log.size() > base + k) ? tid_log[base + k] : -1, exp_seq[k]);
      end
    end
  endtask

  task automatic test_no_interleave();
    int base;
    base = beat_tid_log.size();
    push_pkt(2, 5);
    refresh();
    run_until_beats(beats_seen + 2);
    push_pkt(0, 1);
    refresh();
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (beat_tid_log.size() <= base + k || beat_tid_log[base + k] !== ((k < 5) ? 2 : 0)) begin
        failures++;
        $display("FAIL no_interleave[%0d]: got %0d expected %0d", k,
                 (beat_tid_log.size() > base + k) ? beat_tid_log[base + k] : -1, (k < 5) ? 2 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic        l0;
    logic [1:0]  t0;
    push_pkt(1, 4);
    refresh();
    run_until_beats(beats_seen + 2);
    m_tready = 1'b0;
    cycle();
    d0 = prev_data; l0 = prev_last; t0 = prev_tid;
    cycle();
    cycle();
    checks++;
    if (prev_data !== d0 || prev_last !== l0 || prev_tid !== t0 || m_tvalid !== 1'b1 || t0 !== 2'd1) begin
      failures++;
      $display("FAIL backpressure: got data=%h last=%b tid=%0d valid=%b expected data=%h last=%b tid=1 valid=1",
               prev_data, prev_last, prev_tid, m_tvalid, d0, l0);
    end
    m_tready = 1'b1;
    wait_idle();
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    base = tid_log.size();
    push_pkt(0, 2); push_pkt(0, 1); push_pkt(3, 1);
    refresh();
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tid_log.size() <= base + k || tid_log[base + k] !== ((k == 1) ? 3 : 0)) begin
        failures++;
        $display("FAIL wrap[%0d]: got %0d expected %0d", k,
                 (tid_log.size() > base + k) ? tid_log[base + k] : -1, (k == 1) ? 3 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    push_pkt(2, 4);
    refresh();
    run_until_beats(beats_seen + 2);
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b busy=%b expected 0 0", m_tvalid, busy);
    end
    for (int i = 0; i < N; i++) srcq[i].delete();
    refresh();
    cycle();
    aresetn = 1'b1;
    base = tid_log.size();
    push_pkt(1, 2); push_pkt(0, 3);
    refresh();
    wait_idle();
    checks++;
    if (tid_log.size() < base + 2 || tid_log[base] !== 0 || tid_log[base + 1] !== 1) begin
      failures++;
      $display("FAIL reset_regrant: got %0d,%0d expected 0,1",
               (tid_log.size() > base) ? tid_log[base] : -1,
               (tid_log.size() > base + 1) ? tid_log[base + 1] : -1);
    end
  endtask

  task automatic test_random();
    int src;
    gap_mode = 1; ready_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        src = $urandom_range(0, N - 1);
        if (srcq[src].size() < 8) push_pkt(src, $urandom_range(1, 5));
      end
      cycle();
    end
    wait_idle();
    gap_mode = 0; ready_rand = 0; m_tready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    test_reset();
    test_all_single();
    test_no_interleave();
    test_backpressure();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
